// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and constants for the SPI slave front end.
// FSM state encoding, default widths and the RAM command codes.
package spi_pkg;

   localparam int FRAME_BITS_DEF = 10;
   localparam int DATA_BITS_DEF  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } spi_state_e;

endpackage

// File: rtl/spi_slave_ctrl_miso_serializer.sv
// MISO serializer: loads one read byte per frame and shifts it out MSB first.
// sent_all_o is high once every bit has been driven (including the finishing edge).
module spi_miso_serializer
   import spi_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 miso_o,
   output logic                 sent_all_o
);

   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   logic [DATA_BITS-1:0] sr_q, sr_d;
   logic [BIT_W-1:0]     cnt_q, cnt_d;
   logic                 miso_q, miso_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;
   logic                 finish_s;

   assign finish_s   = active_q && (cnt_q == {BIT_W{1'b0}});
   assign sent_all_o = done_q || finish_s;
   assign miso_o     = miso_q;

   // Next-state logic: first load wins, later loads in the same frame are ignored.
   always_comb begin
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      miso_d   = miso_q;
      active_d = active_q;
      done_d   = done_q;
      if (clear_i) begin
         sr_d     = {DATA_BITS{1'b0}};
         cnt_d    = {BIT_W{1'b0}};
         miso_d   = 1'b0;
         active_d = 1'b0;
         done_d   = 1'b0;
      end else if (load_i && !active_q && !done_q) begin
         sr_d     = {data_i[DATA_BITS-2:0], 1'b0};
         cnt_d    = BIT_W'(DATA_BITS - 1);
         miso_d   = data_i[DATA_BITS-1];
         active_d = 1'b1;
      end else if (active_q) begin
         if (cnt_q != {BIT_W{1'b0}}) begin
            sr_d   = {sr_q[DATA_BITS-2:0], 1'b0};
            cnt_d  = cnt_q - BIT_W'(1);
            miso_d = sr_q[DATA_BITS-1];
         end else begin
            miso_d   = 1'b0;
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end else begin
         miso_d = 1'b0;
      end
   end

   // Serializer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q     <= {DATA_BITS{1'b0}};
         cnt_q    <= {BIT_W{1'b0}};
         miso_q   <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         miso_q   <= miso_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI command words for the RAM and returns read bytes on MISO.
// Optional abort strobe on frame_err is built only when SPI_FRAME_ERR_EN is defined.
module spi_slave_ctrl
   import spi_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MOSI,
   input  logic                  SS_n,
   input  logic [DATA_BITS-1:0]  tx_data,
   input  logic                  tx_valid,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  MISO,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

   spi_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rd_addr_seen_q, rd_addr_seen_d;
   logic [FRAME_BITS-1:0] frame_word_s;
   logic                  seen_set_s;
   logic                  load_s;
   logic                  clear_s;
   logic                  sent_all_s;

   assign frame_word_s = {shift_q[FRAME_BITS-2:0], MOSI};
   assign load_s  = (state_q == READ_DATA) && !SS_n && tx_valid && (cnt_q == CNT_FULL);
   assign clear_s = (state_q != READ_DATA) || SS_n;

   // FSM next state, bit counter, shift register and word hand-off to the RAM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      seen_set_s = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (!SS_n) begin
               state_d = CHK_CMD;
            end else begin
               state_d = IDLE;
            end
         end
         CHK_CMD: begin
            if (SS_n) begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               shift_d = frame_word_s;
               cnt_d   = CNT_W'(1);
               if (!MOSI) begin
                  state_d = WRITE;
               end else if (rd_addr_seen_q) begin
                  state_d = READ_DATA;
               end else begin
                  state_d = READ_ADD;
               end
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               state_d = IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q != CNT_FULL) begin
               shift_d = frame_word_s;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  rx_data_d  = frame_word_s;
                  rx_valid_d = 1'b1;
                  seen_set_s = (state_q == READ_ADD);
               end else begin
                  rx_valid_d = 1'b0;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      if (seen_set_s) begin
         rd_addr_seen_d = 1'b1;
      end else if (sent_all_s) begin
         rd_addr_seen_d = 1'b0;
      end else begin
         rd_addr_seen_d = rd_addr_seen_q;
      end
   end

   // Control and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= {CNT_W{1'b0}};
         shift_q        <= {FRAME_BITS{1'b0}};
         rx_data_q      <= {FRAME_BITS{1'b0}};
         rx_valid_q     <= 1'b0;
         rd_addr_seen_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         shift_q        <= shift_d;
         rx_data_q      <= rx_data_d;
         rx_valid_q     <= rx_valid_d;
         rd_addr_seen_q <= rd_addr_seen_d;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

   spi_miso_serializer #(
      .DATA_BITS (DATA_BITS)
   ) u_miso (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear_s),
      .load_i     (load_s),
      .data_i     (tx_data),
      .miso_o     (MISO),
      .sent_all_o (sent_all_s)
   );

`ifdef SPI_FRAME_ERR_EN
   logic abort_s;
   logic frame_err_q, frame_err_d;

   assign abort_s = (state_q != IDLE) && SS_n;

   // Flag an SS_n rise that cuts off the command word or the read byte.
   always_comb begin
      frame_err_d = 1'b0;
      if (abort_s) begin
         if (cnt_q != CNT_FULL) begin
            frame_err_d = 1'b1;
         end else if ((state_q == READ_DATA) && !sent_all_s) begin
            frame_err_d = 1'b1;
         end else begin
            frame_err_d = 1'b0;
         end
      end else begin
         frame_err_d = 1'b0;
      end
   end

   // Abort strobe register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

endmodule
